// File: rtl/bus_req_arbiter_if.sv
// Request/response bundle between the two bus requesters, the arbiter and the 68k bus-cycle engine.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface bus_req_arbiter_if;
    logic        ENABLE;

    logic        A_ACTIVE;
    logic [23:0] A_ADDRESS;
    logic [31:0] A_DATA;
    logic [2:0]  A_FC;
    logic [1:0]  A_SIZE;
    logic        A_IS_READ;
    logic        A_CLEAR;

    logic        B_ACTIVE;
    logic [23:0] B_ADDRESS;
    logic [31:0] B_DATA;
    logic [2:0]  B_FC;
    logic [1:0]  B_SIZE;
    logic        B_IS_READ;
    logic        B_CLEAR;

    logic [31:0] RESP_DATA;
    logic        RESP_ERROR;
    logic        OWNER_B;

    logic        BUS_ACTIVE;
    logic [23:0] BUS_ADDRESS;
    logic [31:0] BUS_DATA;
    logic [2:0]  BUS_FC;
    logic [1:0]  BUS_SIZE;
    logic        BUS_IS_READ;
    logic        BUS_DONE;
    logic        BUS_ERROR;
    logic [31:0] BUS_DATA_IN;
    logic        BUS_ABORT;

    modport slave (
        input  ENABLE,
        input  A_ACTIVE, A_ADDRESS, A_DATA, A_FC, A_SIZE, A_IS_READ,
        output A_CLEAR,
        input  B_ACTIVE, B_ADDRESS, B_DATA, B_FC, B_SIZE, B_IS_READ,
        output B_CLEAR,
        output RESP_DATA, RESP_ERROR, OWNER_B,
        output BUS_ACTIVE, BUS_ADDRESS, BUS_DATA, BUS_FC, BUS_SIZE, BUS_IS_READ,
        input  BUS_DONE, BUS_ERROR, BUS_DATA_IN,
        output BUS_ABORT
    );

    modport master (
        output ENABLE,
        output A_ACTIVE, A_ADDRESS, A_DATA, A_FC, A_SIZE, A_IS_READ,
        input  A_CLEAR,
        output B_ACTIVE, B_ADDRESS, B_DATA, B_FC, B_SIZE, B_IS_READ,
        input  B_CLEAR,
        input  RESP_DATA, RESP_ERROR, OWNER_B,
        input  BUS_ACTIVE, BUS_ADDRESS, BUS_DATA, BUS_FC, BUS_SIZE, BUS_IS_READ,
        output BUS_DONE, BUS_ERROR, BUS_DATA_IN,
        input  BUS_ABORT
    );
endinterface

// File: rtl/bus_req_arbiter.sv
// Two-requester arbiter in front of the single 68k bus-cycle engine: A (Pi registers) vs B (on-FPGA),
// with anti-starvation for B and a watchdog that aborts hung bus cycles. All flops on falling SYSCLK.
module bus_req_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_W      = 12,
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input logic              SYSCLK,
    input logic              RESET,
    bus_req_arbiter_if.slave arb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [23:0] address;
        logic [31:0] data;
        logic [2:0]  fc;
        logic [1:0]  size;
        logic        is_read;
    } req_t;

    localparam logic [3:0]           STREAK_MAX = 4'hF;
    localparam logic [3:0]           STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           streak_q, streak_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    req_t                 req_q, req_d;
    req_t                 req_a, req_b;
    logic                 owner_b_q, owner_b_d;
    logic                 bus_active_q, bus_active_d;
    logic [31:0]          resp_data_q, resp_data_d;
    logic                 resp_error_q, resp_error_d;
    logic                 a_clear_q, a_clear_d;
    logic                 b_clear_q, b_clear_d;
    logic                 abort_q, abort_d;
    logic                 pick_b;

    assign req_a = {arb.A_ADDRESS, arb.A_DATA, arb.A_FC, arb.A_SIZE, arb.A_IS_READ};
    assign req_b = {arb.B_ADDRESS, arb.B_DATA, arb.B_FC, arb.B_SIZE, arb.B_IS_READ};

    always_ff @(negedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            wdog_q       <= '0;
            req_q        <= '0;
            owner_b_q    <= 1'b0;
            bus_active_q <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            a_clear_q    <= 1'b0;
            b_clear_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            wdog_q       <= wdog_d;
            req_q        <= req_d;
            owner_b_q    <= owner_b_d;
            bus_active_q <= bus_active_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            a_clear_q    <= a_clear_d;
            b_clear_q    <= b_clear_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        wdog_d       = wdog_q;
        req_d        = req_q;
        owner_b_d    = owner_b_q;
        bus_active_d = bus_active_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        a_clear_d    = 1'b0;
        b_clear_d    = 1'b0;
        abort_d      = 1'b0;
        pick_b       = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb.ENABLE && (arb.A_ACTIVE || arb.B_ACTIVE)) begin
                    // A normally wins a tie; B is forced once A has won STARVE_LIMIT ties in a row
                    pick_b       = arb.B_ACTIVE && (!arb.A_ACTIVE || (streak_q >= STARVE_LIM));
                    req_d        = pick_b ? req_b : req_a;
                    owner_b_d    = pick_b;
                    bus_active_d = 1'b1;
                    wdog_d       = '0;
                    state_d      = BUSY;
                    if (pick_b || !arb.B_ACTIVE) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end
            end
            BUSY: begin
                if (arb.BUS_DONE) begin
                    resp_data_d  = arb.BUS_DATA_IN;
                    resp_error_d = arb.BUS_ERROR;
                    bus_active_d = 1'b0;
                    a_clear_d    = !owner_b_q;
                    b_clear_d    = owner_b_q;
                    state_d      = DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    abort_d      = 1'b1;
                    resp_error_d = 1'b1;
                    bus_active_d = 1'b0;
                    a_clear_d    = !owner_b_q;
                    b_clear_d    = owner_b_q;
                    state_d      = DONE;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign arb.A_CLEAR     = a_clear_q;
    assign arb.B_CLEAR     = b_clear_q;
    assign arb.RESP_DATA   = resp_data_q;
    assign arb.RESP_ERROR  = resp_error_q;
    assign arb.OWNER_B     = owner_b_q;
    assign arb.BUS_ACTIVE  = bus_active_q;
    assign arb.BUS_ADDRESS = req_q.address;
    assign arb.BUS_DATA    = req_q.data;
    assign arb.BUS_FC      = req_q.fc;
    assign arb.BUS_SIZE    = req_q.size;
    assign arb.BUS_IS_READ = req_q.is_read;
    assign arb.BUS_ABORT   = abort_q;

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Directed plus randomized checks of bus_req_arbiter against a transaction-level model
// (grant history for starvation, latency/timeout arithmetic for completion).
module tb_bus_req_arbiter;

    localparam int STARVE = 4;
    localparam int TO     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_req_arbiter_if ifc();

    bus_req_arbiter #(
        .STARVE_LIMIT  (STARVE),
        .TIMEOUT_W     (12),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .SYSCLK(clk),
        .RESET (rst),
        .arb   (ifc)
    );

    typedef struct {
        logic won_b;
        logic b_waiting;
    } grant_t;

    grant_t      hist[$];
    logic [31:0] m_resp_data;
    logic        m_resp_err;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // consecutive A wins taken while B was waiting, since the last B win or uncontested A win
    function automatic int model_streak();
        int s = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].won_b || !hist[i].b_waiting) break;
            s++;
        end
        return (s > 15) ? 15 : s;
    endfunction

    function automatic logic [63:0] bus_fields();
        return 64'({ifc.BUS_ADDRESS, ifc.BUS_FC, ifc.BUS_SIZE, ifc.BUS_IS_READ});
    endfunction

    task automatic raise_a();
        ifc.A_ACTIVE  = 1'b1;
        ifc.A_ADDRESS = 24'($urandom);
        ifc.A_DATA    = $urandom;
        ifc.A_FC      = 3'($urandom);
        ifc.A_SIZE    = 2'($urandom);
        ifc.A_IS_READ = 1'($urandom);
    endtask

    task automatic raise_b();
        ifc.B_ACTIVE  = 1'b1;
        ifc.B_ADDRESS = 24'($urandom);
        ifc.B_DATA    = $urandom;
        ifc.B_FC      = 3'($urandom);
        ifc.B_SIZE    = 2'($urandom);
        ifc.B_IS_READ = 1'($urandom);
    endtask

    // Called in IDLE with requests already presented; returns at the IDLE tick after DONE.
    // lat = BUSY cycle on which BUS_DONE is driven; outside 1..TO the watchdog must fire.
    task automatic do_txn(input int lat, input logic err, input logic [31:0] rdata,
                          input logic drop_mid, output logic won_b);
        logic        exp_b;
        logic [63:0] e_fields;
        logic [31:0] e_wdata;
        logic        to;
        int          comp_at;

        exp_b = ifc.B_ACTIVE && (!ifc.A_ACTIVE || (model_streak() >= STARVE));
        if (exp_b) begin
            e_fields = 64'({ifc.B_ADDRESS, ifc.B_FC, ifc.B_SIZE, ifc.B_IS_READ});
            e_wdata  = ifc.B_DATA;
        end else begin
            e_fields = 64'({ifc.A_ADDRESS, ifc.A_FC, ifc.A_SIZE, ifc.A_IS_READ});
            e_wdata  = ifc.A_DATA;
        end
        hist.push_back('{exp_b, ifc.B_ACTIVE});
        won_b   = exp_b;
        to      = (lat < 1) || (lat > TO);
        comp_at = to ? TO : lat;

        tick();
        check("grant_active", 64'(ifc.BUS_ACTIVE), 64'(1));
        check("grant_owner", 64'(ifc.OWNER_B), 64'(exp_b));
        check("grant_fields", bus_fields(), e_fields);
        check("grant_wdata", 64'(ifc.BUS_DATA), 64'(e_wdata));

        for (int n = 1; n <= comp_at; n++) begin
            ifc.BUS_DONE    = (n == lat);
            ifc.BUS_ERROR   = (n == lat) ? err : 1'($urandom);
            ifc.BUS_DATA_IN = (n == lat) ? rdata : $urandom;
            if (drop_mid && n == 1) begin
                ifc.ENABLE = 1'b0;
                if (exp_b) begin
                    ifc.B_ACTIVE  = 1'b0;
                    ifc.B_ADDRESS = 24'($urandom);
                end else begin
                    ifc.A_ACTIVE  = 1'b0;
                    ifc.A_ADDRESS = 24'($urandom);
                end
            end
            tick();
            if (n < comp_at)
                check("busy_hold", 64'({ifc.BUS_ACTIVE, ifc.A_CLEAR, ifc.B_CLEAR, ifc.BUS_ABORT}),
                      64'(4'b1000));
        end

        if (!to) begin
            m_resp_data = rdata;
            m_resp_err  = err;
        end else begin
            m_resp_err = 1'b1;
        end
        check("done_pulses", 64'({ifc.BUS_ACTIVE, ifc.A_CLEAR, ifc.B_CLEAR, ifc.BUS_ABORT}),
              64'({1'b0, !exp_b, exp_b, to}));
        check("done_resp", 64'({ifc.RESP_ERROR, ifc.RESP_DATA}), 64'({m_resp_err, m_resp_data}));
        check("done_frozen", bus_fields(), e_fields);

        ifc.BUS_DONE = 1'b0;
        ifc.ENABLE   = 1'b1;
        if (exp_b) ifc.B_ACTIVE = 1'b0;
        else       ifc.A_ACTIVE = 1'b0;
        tick();
        check("idle_quiet", 64'({ifc.BUS_ACTIVE, ifc.A_CLEAR, ifc.B_CLEAR, ifc.BUS_ABORT, ifc.OWNER_B}),
              64'({4'b0000, exp_b}));
        check("idle_resp", 64'({ifc.RESP_ERROR, ifc.RESP_DATA}), 64'({m_resp_err, m_resp_data}));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed simulation still running expected finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        logic       wb;
        logic [9:0] order;
        logic [31:0] held;

        ifc.ENABLE = 1'b0;
        ifc.A_ACTIVE = 1'b0; ifc.A_ADDRESS = '0; ifc.A_DATA = '0; ifc.A_FC = '0; ifc.A_SIZE = '0; ifc.A_IS_READ = 1'b0;
        ifc.B_ACTIVE = 1'b0; ifc.B_ADDRESS = '0; ifc.B_DATA = '0; ifc.B_FC = '0; ifc.B_SIZE = '0; ifc.B_IS_READ = 1'b0;
        ifc.BUS_DONE = 1'b0; ifc.BUS_ERROR = 1'b0; ifc.BUS_DATA_IN = '0;
        m_resp_data = '0;
        m_resp_err  = 1'b0;
        order       = '0;

        tick();
        tick();
        check("reset_ctrl", 64'({ifc.BUS_ACTIVE, ifc.A_CLEAR, ifc.B_CLEAR, ifc.BUS_ABORT, ifc.OWNER_B, ifc.RESP_ERROR}), 64'(0));
        check("reset_data", 64'({ifc.RESP_DATA, ifc.BUS_ADDRESS}), 64'(0));
        rst        = 1'b0;
        ifc.ENABLE = 1'b1;
        tick();

        // A only: write to 0xDFF180, done on the 5th BUSY cycle
        raise_a();
        ifc.A_ADDRESS = 24'hDFF180;
        ifc.A_IS_READ = 1'b0;
        do_txn(5, 1'b0, 32'hCAFEF00D, 1'b0, wb);
        check("a_only_owner", 64'(wb), 64'(0));

        // B read returning 0x12345678
        raise_b();
        ifc.B_IS_READ = 1'b1;
        do_txn(3, 1'b0, 32'h12345678, 1'b0, wb);
        check("b_read_data", 64'({ifc.OWNER_B, ifc.RESP_ERROR, ifc.RESP_DATA}), 64'({1'b1, 1'b0, 32'h12345678}));

        // Both held continuously: A,A,A,A,B,A,A,A,A,B
        for (int i = 0; i < 10; i++) begin
            if (!ifc.A_ACTIVE) raise_a();
            if (!ifc.B_ACTIVE) raise_b();
            do_txn(1 + int'($urandom_range(3, 0)), 1'($urandom), $urandom, 1'b0, wb);
            order[i] = wb;
        end
        check("starve_order", 64'(order), 64'(10'b1000010000));
        ifc.A_ACTIVE = 1'b0;
        ifc.B_ACTIVE = 1'b0;
        tick();

        // Watchdog: no BUS_DONE -> abort 16 cycles after grant; BUS_DONE on cycle 16 -> no abort
        raise_a();
        do_txn(0, 1'b0, 32'h0, 1'b0, wb);
        check("timeout_err", 64'(ifc.RESP_ERROR), 64'(1));
        raise_b();
        do_txn(TO, 1'b0, 32'h0BADBEEF, 1'b0, wb);
        check("edge_done_err", 64'({ifc.RESP_ERROR, ifc.RESP_DATA}), 64'({1'b0, 32'h0BADBEEF}));
        raise_a();
        do_txn(TO, 1'b1, 32'h55AA55AA, 1'b0, wb);

        // ENABLE gating, then abandonment mid-BUSY
        ifc.ENABLE = 1'b0;
        raise_a();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gated_no_grant", 64'(ifc.BUS_ACTIVE), 64'(0));
        end
        ifc.ENABLE = 1'b1;
        do_txn(4, 1'b0, 32'hA5A50001, 1'b1, wb);
        check("abandon_owner", 64'(wb), 64'(0));

        // Stray BUS_DONE in IDLE is ignored
        held            = ifc.RESP_DATA;
        ifc.BUS_DONE    = 1'b1;
        ifc.BUS_ERROR   = 1'b1;
        ifc.BUS_DATA_IN = ~held;
        tick();
        ifc.BUS_DONE = 1'b0;
        check("stray_done", 64'({ifc.A_CLEAR, ifc.B_CLEAR, ifc.RESP_ERROR, ifc.RESP_DATA}),
              64'({2'b00, m_resp_err, m_resp_data}));
        tick();

        // Reset in the middle of a BUSY cycle while A holds a streak of 4
        for (int i = 0; i < 3; i++) begin
            if (!ifc.A_ACTIVE) raise_a();
            if (!ifc.B_ACTIVE) raise_b();
            do_txn(2, 1'b0, $urandom, 1'b0, wb);
        end
        raise_a();
        tick();
        check("pre_reset_busy", 64'({ifc.BUS_ACTIVE, ifc.OWNER_B}), 64'(2'b10));
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("reset_async", 64'({ifc.BUS_ACTIVE, ifc.A_CLEAR, ifc.B_CLEAR, ifc.BUS_ABORT, ifc.OWNER_B, ifc.RESP_ERROR}), 64'(0));
        tick();
        check("reset_no_clear", 64'({ifc.A_CLEAR, ifc.B_CLEAR, ifc.BUS_ACTIVE}), 64'(0));
        rst = 1'b0;
        hist.delete();
        m_resp_data = '0;
        m_resp_err  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!ifc.A_ACTIVE) raise_a();
            if (!ifc.B_ACTIVE) raise_b();
            do_txn(1, 1'b0, $urandom, 1'b0, wb);
            order[i] = wb;
        end
        check("post_reset_order", 64'(order[4:0]), 64'(5'b10000));

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int unsigned act;
            int          lat;
            act = $urandom_range(3, 1);
            if (act[0] && !ifc.A_ACTIVE) raise_a();
            if (act[1] && !ifc.B_ACTIVE) raise_b();
            if ($urandom_range(3, 0) == 0) begin
                ifc.ENABLE = 1'b0;
                tick();
                check("rand_gated", 64'(ifc.BUS_ACTIVE), 64'(0));
                ifc.ENABLE = 1'b1;
            end
            lat = ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 13)) : int'($urandom_range(6, 1));
            do_txn(lat, 1'($urandom), $urandom, ($urandom_range(3, 0) == 0), wb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
